// File: rtl/pop_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : pop_arbiter
// Description : Round-robin burst arbiter popping four source FIFOs into one
//               downstream FIFO, with a configurable burst length.
// Revision    : 1.0 - initial release
// ============================================================================
module pop_arbiter #(
    parameter int BURST_W = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               init,
    input  logic [BURST_W-1:0] burst_cfg,
    input  logic [3:0]         empty_F,
    input  logic               dst_almost_full,
    output logic [3:0]         pop_F,
    output logic               push_dst,
    output logic [1:0]         sel,
    output logic               idle,
    output logic [1:0]         state
);

    typedef enum logic [1:0] {
        ST_RESET  = 2'd0,
        ST_INIT   = 2'd1,
        ST_IDLE   = 2'd2,
        ST_ACTIVE = 2'd3
    } state_t;

    localparam logic [BURST_W:0] c_max_len = {1'b1, {BURST_W{1'b0}}};

    state_t             r_state;
    state_t             w_state_nxt;
    logic [1:0]         r_ptr;
    logic [1:0]         w_ptr_nxt;
    logic [BURST_W-1:0] r_burst_cnt;
    logic [BURST_W-1:0] w_cnt_nxt;
    logic [BURST_W-1:0] r_burst_len;
    logic [BURST_W-1:0] w_len_nxt;
    logic [BURST_W:0]   w_eff_len;
    logic [BURST_W:0]   w_cnt_inc;
    logic [1:0]         w_next_ptr;
    logic [1:0]         w_cand;
    logic               w_pop_ok;

    assign w_pop_ok  = (r_state == ST_ACTIVE) & ~reset & ~init
                     & ~empty_F[r_ptr] & ~dst_almost_full;
    assign pop_F     = w_pop_ok ? (4'b0001 << r_ptr) : 4'b0000;
    assign idle      = (r_state == ST_IDLE);
    assign state     = r_state;

    // A zero configuration encodes the maximum burst of 2^BURST_W.
    assign w_eff_len = (r_burst_len == '0) ? c_max_len : {1'b0, r_burst_len};
    assign w_cnt_inc = {1'b0, r_burst_cnt} + {{BURST_W{1'b0}}, 1'b1};

    // Nearest non-empty FIFO after ptr; scanned far-to-near so the nearest wins.
    always_comb begin
        w_next_ptr = r_ptr;
        w_cand     = r_ptr;
        for (int k = 3; k >= 1; k--) begin
            w_cand = r_ptr + 2'(k);
            if (!empty_F[w_cand]) begin
                w_next_ptr = w_cand;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_burst_cnt;
        w_len_nxt   = r_burst_len;
        case (r_state)
            ST_RESET: begin
                w_state_nxt = ST_INIT;
            end
            ST_INIT: begin
                if (init) begin
                    w_len_nxt = burst_cfg;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (init) begin
                    w_state_nxt = ST_INIT;
                    w_ptr_nxt   = 2'd0;
                    w_cnt_nxt   = '0;
                end else if ((empty_F != 4'b1111) && !dst_almost_full) begin
                    w_state_nxt = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (init) begin
                    w_state_nxt = ST_INIT;
                    w_ptr_nxt   = 2'd0;
                    w_cnt_nxt   = '0;
                end else begin
                    if (empty_F == 4'b1111) begin
                        w_state_nxt = ST_IDLE;
                    end
                    if (w_pop_ok) begin
                        if (w_cnt_inc == w_eff_len) begin
                            w_ptr_nxt = w_next_ptr;
                            w_cnt_nxt = '0;
                        end else begin
                            w_cnt_nxt = w_cnt_inc[BURST_W-1:0];
                        end
                    end else if (!dst_almost_full) begin
                        // Granted FIFO ran dry: hand over and restart the burst.
                        w_ptr_nxt = w_next_ptr;
                        w_cnt_nxt = '0;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_RESET;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_RESET;
            r_ptr       <= 2'd0;
            r_burst_cnt <= '0;
            r_burst_len <= {{(BURST_W-1){1'b0}}, 1'b1};
            push_dst    <= 1'b0;
            sel         <= 2'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_burst_cnt <= w_cnt_nxt;
            r_burst_len <= w_len_nxt;
            push_dst    <= |pop_F;
            sel         <= r_ptr;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pop_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_pop_arbiter
// Description : Scoreboard bench for pop_arbiter with a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pop_arbiter;

    localparam int BURST_W = 3;

    logic               clk = 1'b0;
    logic               reset;
    logic               init;
    logic [BURST_W-1:0] burst_cfg;
    logic [3:0]         empty_F;
    logic               dst_almost_full;
    logic [3:0]         pop_F;
    logic               push_dst;
    logic [1:0]         sel;
    logic               idle;
    logic [1:0]         state;

    pop_arbiter #(.BURST_W(BURST_W)) dut (
        .clk             (clk),
        .reset           (reset),
        .init            (init),
        .burst_cfg       (burst_cfg),
        .empty_F         (empty_F),
        .dst_almost_full (dst_almost_full),
        .pop_F           (pop_F),
        .push_dst        (push_dst),
        .sel             (sel),
        .idle            (idle),
        .state           (state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_q[$];
    bit mon_en   = 1'b0;

    // Reference model: 0=RESET 1=INIT 2=IDLE 3=ACTIVE
    int m_state, m_ptr, m_cnt, m_len;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    function automatic int next_full(input int p, input logic [3:0] emp);
        for (int k = 1; k <= 3; k++) begin
            if (!emp[(p + k) % 4]) return (p + k) % 4;
        end
        return p;
    endfunction

    task automatic cycle(input logic rst, input logic ini, input int cfg,
                         input logic [3:0] emp, input logic daf);
        logic [3:0] exp_pop;
        int eff;
        @(negedge clk);
        reset = rst; init = ini; burst_cfg = BURST_W'(cfg);
        empty_F = emp; dst_almost_full = daf;
        #1;
        exp_pop = 4'b0;
        if (m_state == 3 && !rst && !ini && !emp[m_ptr] && !daf)
            exp_pop[m_ptr] = 1'b1;
        chk("pop_F", pop_F, exp_pop);
        chk("state", state, m_state);
        chk("idle", idle, m_state == 2);
        if (exp_pop != 0) exp_q.push_back(m_ptr);

        if (rst) begin
            m_state = 0; m_ptr = 0; m_cnt = 0; m_len = 1;
        end else begin
            case (m_state)
                0: m_state = 1;
                1: if (ini) m_len = cfg % (1 << BURST_W); else m_state = 2;
                2: begin
                    if (ini) begin m_state = 1; m_ptr = 0; m_cnt = 0; end
                    else if (emp != 4'hF && !daf) m_state = 3;
                end
                default: begin
                    if (ini) begin
                        m_state = 1; m_ptr = 0; m_cnt = 0;
                    end else begin
                        eff = (m_len == 0) ? (1 << BURST_W) : m_len;
                        if (exp_pop != 0) begin
                            if (m_cnt + 1 == eff) begin
                                m_cnt = 0; m_ptr = next_full(m_ptr, emp);
                            end else begin
                                m_cnt = m_cnt + 1;
                            end
                        end else if (!daf) begin
                            m_cnt = 0; m_ptr = next_full(m_ptr, emp);
                        end
                        if (emp == 4'hF) m_state = 2;
                    end
                end
            endcase
        end
    endtask

    // Monitor: every push must match a predicted pop, in order, one cycle late.
    initial begin
        int want;
        forever begin
            @(posedge clk);
            #2;
            if (mon_en) begin
                if (push_dst === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        chk("push_unexpected", 1, 0);
                    end else begin
                        want = exp_q.pop_front();
                        chk("sel", sel, want);
                    end
                end else begin
                    chk("push_missing", exp_q.size(), 0);
                    exp_q.delete();
                end
            end
        end
    end

    initial begin
        logic [3:0] emp;
        reset = 1'b1; init = 1'b0; burst_cfg = '0;
        empty_F = 4'hF; dst_almost_full = 1'b0;
        repeat (2) @(posedge clk);
        m_state = 0; m_ptr = 0; m_cnt = 0; m_len = 1;
        mon_en = 1'b1;

        // Basic burst on FIFO 0
        cycle(1, 0, 0, 4'b1110, 0);
        cycle(0, 1, 2, 4'b1110, 0);
        cycle(0, 1, 2, 4'b1110, 0);
        repeat (6) cycle(0, 0, 0, 4'b1110, 0);

        // Round-robin with burst 2
        cycle(0, 1, 2, 4'b0000, 0);
        repeat (12) cycle(0, 0, 0, 4'b0000, 0);

        // Empty skip, then backpressure mid-burst
        repeat (3) cycle(0, 0, 0, 4'b1010, 0);
        cycle(0, 0, 0, 4'b0000, 0);
        repeat (3) cycle(0, 0, 0, 4'b0000, 1);
        repeat (4) cycle(0, 0, 0, 4'b0000, 0);

        // Drain, then resume
        repeat (2) cycle(0, 0, 0, 4'b1111, 0);
        repeat (3) cycle(0, 0, 0, 4'b0100, 0);

        // Re-init with cfg 0 (burst 8), abort by init then by reset
        cycle(0, 1, 0, 4'b0000, 0);
        repeat (12) cycle(0, 0, 0, 4'b0000, 0);
        cycle(0, 1, 0, 4'b0000, 0);
        repeat (5) cycle(0, 0, 0, 4'b0000, 0);
        cycle(1, 0, 0, 4'b0000, 0);
        repeat (6) cycle(0, 0, 0, 4'b0000, 0);

        // Randomized traffic
        emp = 4'b0000;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 1) == 0) emp = 4'($urandom_range(0, 15));
            cycle($urandom_range(0, 79) == 0, $urandom_range(0, 39) == 0,
                  $urandom_range(0, 7), emp, $urandom_range(0, 3) == 0);
        end

        repeat (3) cycle(0, 0, 0, 4'hF, 0);
        chk("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
